// File: rtl/sift_pkg.sv
// Shared types and helpers for the SIFT stage sequencer: FSM state encoding
// and the "next enabled stage" search used to walk the stage list in order.
package sift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_GAP  = 3'd2,
    ST_FIN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int MAX_STAGES = 32;

  // Lowest set bit strictly above 'after'; -1 when no such bit exists.
  function automatic int next_enabled(input logic [MAX_STAGES-1:0] en, input int after);
    next_enabled = -1;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (en[i] && (i > after)) next_enabled = i;
    end
  endfunction

endpackage

// File: rtl/sift_mem_port_mux.sv
// Routes the selected stage's SRAM address/write-enable bundle onto the shared
// ports; everything is forced to zero when the selection is not valid.
module sift_mem_port_mux #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_MEM    = 4,
  parameter int ADDR_W     = 9,
  parameter int SEL_W      = 2
) (
  input  logic                                valid_i,
  input  logic [SEL_W-1:0]                    sel_i,
  input  logic [NUM_STAGES*NUM_MEM*ADDR_W-1:0] stage_addr_i,
  input  logic [NUM_STAGES*NUM_MEM-1:0]        stage_we_i,
  output logic [NUM_MEM*ADDR_W-1:0]            mem_addr_o,
  output logic [NUM_MEM-1:0]                   mem_we_o
);

  always_comb begin
    mem_addr_o = '0;
    mem_we_o   = '0;
    if (valid_i && (int'(sel_i) < NUM_STAGES)) begin
      mem_addr_o = stage_addr_i[int'(sel_i)*NUM_MEM*ADDR_W +: NUM_MEM*ADDR_W];
      mem_we_o   = stage_we_i[int'(sel_i)*NUM_MEM +: NUM_MEM];
    end
  end

endmodule

// File: rtl/sift_stage_sequencer.sv
// Top-level SIFT pipeline sequencer: runs enabled stages in order with a
// one-cycle gap between them, watchdog, abort and per-stage cycle counters.
module sift_stage_sequencer
  import sift_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_MEM    = 4,
  parameter int ADDR_W     = 9,
  parameter int TIMEOUT_W  = 24,
  parameter int CNT_W      = 32,
  localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [NUM_STAGES-1:0]                stage_enable,
  input  logic [TIMEOUT_W-1:0]                 timeout_limit,
  input  logic [NUM_STAGES-1:0]                stage_done,
  input  logic [NUM_STAGES*NUM_MEM*ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES*NUM_MEM-1:0]        stage_we,
  output logic [NUM_STAGES-1:0]                stage_start,
  output logic [NUM_MEM*ADDR_W-1:0]            mem_addr,
  output logic [NUM_MEM-1:0]                   mem_we,
  output logic [SW-1:0]                        cur_stage,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 aborted,
  output logic                                 error,
  output logic [SW-1:0]                        err_stage,
  output logic [NUM_STAGES*CNT_W-1:0]          stage_cycles
);

  localparam int WIDE_W = (TIMEOUT_W + 1 > CNT_W) ? TIMEOUT_W + 1 : CNT_W;

  state_t                      state_q;
  logic [NUM_STAGES-1:0]       en_q;
  logic [SW-1:0]               cur_q;
  logic [TIMEOUT_W-1:0]        cnt_q;
  logic [NUM_STAGES-1:0]       start_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        aborted_q;
  logic                        error_q;
  logic [SW-1:0]               err_stage_q;
  logic [NUM_STAGES*CNT_W-1:0] cycles_q;

  logic [TIMEOUT_W:0]    cnt_inc;
  logic [TIMEOUT_W-1:0]  cnt_sat;
  logic                  timeout_hit;
  logic [WIDE_W-1:0]     cnt_wide;
  logic [CNT_W-1:0]      cyc_val;
  int                    first_idx;
  int                    next_idx;
  logic [NUM_STAGES-1:0] first_oh;
  logic [NUM_STAGES-1:0] next_oh;

  // The extra carry bit keeps a saturated counter from ever matching the limit.
  assign cnt_inc     = {1'b0, cnt_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign cnt_sat     = (&cnt_q) ? cnt_q : cnt_inc[TIMEOUT_W-1:0];
  assign timeout_hit = (timeout_limit != '0) && (cnt_inc == {1'b0, timeout_limit});
  assign cnt_wide    = WIDE_W'(cnt_inc);
  assign cyc_val     = (cnt_wide > WIDE_W'({CNT_W{1'b1}})) ? '1 : cnt_wide[CNT_W-1:0];

  assign first_idx = next_enabled(MAX_STAGES'(stage_enable), -1);
  assign next_idx  = next_enabled(MAX_STAGES'(en_q), int'(cur_q));
  assign first_oh  = NUM_STAGES'(1) << first_idx;
  assign next_oh   = NUM_STAGES'(1) << next_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      en_q        <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      error_q     <= 1'b0;
      err_stage_q <= '0;
      cycles_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            en_q        <= stage_enable;
            error_q     <= 1'b0;
            err_stage_q <= '0;
            cycles_q    <= '0;
            cnt_q       <= '0;
            if (|stage_enable) begin
              state_q <= ST_RUN;
              cur_q   <= SW'(first_idx);
              start_q <= first_oh;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_sat;
          if (abort) begin
            state_q   <= ST_IDLE;
            aborted_q <= 1'b1;
            start_q   <= '0;
            busy_q    <= 1'b0;
          end else if (stage_done[cur_q]) begin
            cycles_q[int'(cur_q)*CNT_W +: CNT_W] <= cyc_val;
            state_q <= ST_GAP;
            start_q <= '0;
          end else if (timeout_hit) begin
            state_q     <= ST_ERR;
            error_q     <= 1'b1;
            err_stage_q <= cur_q;
            start_q     <= '0;
            busy_q      <= 1'b0;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (next_idx >= 0) begin
            state_q <= ST_RUN;
            cur_q   <= SW'(next_idx);
            cnt_q   <= '0;
            start_q <= next_oh;
          end else begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sift_mem_port_mux #(
    .NUM_STAGES(NUM_STAGES),
    .NUM_MEM   (NUM_MEM),
    .ADDR_W    (ADDR_W),
    .SEL_W     (SW)
  ) u_mux (
    .valid_i     (state_q == ST_RUN),
    .sel_i       (cur_q),
    .stage_addr_i(stage_addr),
    .stage_we_i  (stage_we),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we)
  );

  assign stage_start  = start_q;
  assign cur_stage    = cur_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign error        = error_q;
  assign err_stage    = err_stage_q;
  assign stage_cycles = cycles_q;

endmodule

// File: tb/tb_sift_stage_sequencer.sv
// Scoreboard bench for sift_stage_sequencer: a run-level model expands each
// run into per-cycle expectations plus one completion event per run.
module tb_sift_stage_sequencer;

  localparam int NS = 3;
  localparam int NM = 4;
  localparam int AW = 9;
  localparam int TW = 24;
  localparam int CW = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [NS-1:0]    stage_enable;
  logic [TW-1:0]    timeout_limit;
  logic [NS-1:0]    stage_done;
  logic [NS*NM*AW-1:0] stage_addr;
  logic [NS*NM-1:0] stage_we;
  logic [NS-1:0]    stage_start;
  logic [NM*AW-1:0] mem_addr;
  logic [NM-1:0]    mem_we;
  logic [1:0]       cur_stage;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             error;
  logic [1:0]       err_stage;
  logic [NS*CW-1:0] stage_cycles;

  sift_stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stage_enable(stage_enable), .timeout_limit(timeout_limit),
    .stage_done(stage_done), .stage_addr(stage_addr), .stage_we(stage_we),
    .stage_start(stage_start), .mem_addr(mem_addr), .mem_we(mem_we),
    .cur_stage(cur_stage), .busy(busy), .done(done), .aborted(aborted),
    .error(error), .err_stage(err_stage), .stage_cycles(stage_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int stg;
    bit busy;
    bit dn;
    bit ab;
    bit er;
    int erStg;
    bit doneIn;
    bit abortIn;
  } cyc_t;

  typedef struct {
    int kind;
    logic [2:0][31:0] cyc;
    int erStg;
    int lat;
    int startCyc;
  } ev_t;

  cyc_t plan[$];
  cyc_t cycQ[$];
  ev_t  evQ[$];

  int nChecks = 0;
  int nFails  = 0;
  int cycNum  = 0;
  bit errPrev = 1'b0;

  always @(posedge clk) cycNum++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycNum);
    end
  endtask

  function automatic cyc_t mk(int stg, bit bsy, bit dn, bit ab, bit er, int erStg, bit di, bit ai);
    cyc_t c;
    c.stg = stg; c.busy = bsy; c.dn = dn; c.ab = ab; c.er = er;
    c.erStg = erStg; c.doneIn = di; c.abortIn = ai;
    return c;
  endfunction

  // Run model: each enabled stage runs until the earliest of abort, done or
  // watchdog (that priority on ties), then costs one extra cycle (gap/exit).
  task automatic buildRun(input logic [2:0] en, input int d0, input int d1, input int d2,
                          input int lim, input int abStg, input int abCyc, output ev_t ev);
    int d[3];
    int len;
    bit stop;
    bit errSeen;
    int errStg;
    d[0] = d0; d[1] = d1; d[2] = d2;
    plan.delete();
    ev.kind = 0; ev.cyc = '0; ev.erStg = 0; ev.startCyc = 0;
    stop = 1'b0; errSeen = 1'b0; errStg = 0;
    for (int k = 0; k < NS; k++) begin
      if (!stop && en[k]) begin
        len = 1 << 30;
        if (d[k] > 0) len = d[k];
        if (lim > 0 && lim < len) len = lim;
        if (abStg == k && abCyc > 0 && abCyc <= len) len = abCyc;
        for (int r = 1; r <= len; r++)
          plan.push_back(mk(k, 1, 0, 0, 0, 0, r == d[k], abStg == k && r == abCyc));
        if (abStg == k && abCyc == len) begin
          plan.push_back(mk(-1, 0, 0, 1, 0, 0, 0, 0));
          ev.kind = 1; stop = 1'b1;
        end else if (d[k] == len) begin
          ev.cyc[k] = len;
          plan.push_back(mk(-1, 1, 0, 0, 0, 0, 0, abStg == k && abCyc == 0));
          if (abStg == k && abCyc == 0) begin
            plan.push_back(mk(-1, 0, 0, 1, 0, 0, 0, 0));
            ev.kind = 1; stop = 1'b1;
          end
        end else begin
          plan.push_back(mk(-1, 0, 0, 0, 1, k, 0, 0));
          ev.kind = 2; ev.erStg = k; stop = 1'b1;
          errSeen = 1'b1; errStg = k;
        end
      end
    end
    if (!stop) plan.push_back(mk(-1, 0, 1, 0, 0, 0, 0, 0));
    ev.lat = plan.size();
    plan.push_back(mk(-1, 0, 0, 0, errSeen, errStg, 0, 0));
  endtask

  task automatic applyStimulus(input logic [2:0] en, input int d0, input int d1, input int d2,
                               input int lim, input int abStg, input int abCyc,
                               input bit directed, input int stopAfter);
    ev_t ev;
    logic [127:0] rnd;
    logic [NS-1:0] sd;
    buildRun(en, d0, d1, d2, lim, abStg, abCyc, ev);
    stage_enable  = en;
    timeout_limit = TW'(lim);
    start         = 1'b1;
    abort         = 1'b0;
    ev.startCyc   = cycNum;
    evQ.push_back(ev);
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk);
      #1;
      start = plan[i].busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (plan[i].busy) stage_enable = NS'($urandom);
      sd = NS'($urandom);
      if (plan[i].stg >= 0) sd[plan[i].stg] = plan[i].doneIn;
      stage_done = sd;
      abort = plan[i].abortIn;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      stage_addr = rnd[NS*NM*AW-1:0];
      stage_we   = NS*NM'($urandom);
      if (directed && plan[i].stg == 2) begin
        stage_addr[(2*NM+3)*AW +: AW] = 9'h1A5;
        stage_we[2*NM +: NM] = 4'b1000;
      end
      if (i == stopAfter) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_stage_start", stage_start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_aborted", aborted, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_cur_stage", cur_stage, 0);
        checkOutput("rst_cycles0", stage_cycles[0 +: CW], 0);
        evQ.delete();
        cycQ.delete();
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        break;
      end
      cycQ.push_back(plan[i]);
    end
  endtask

  // Monitor: per-cycle expectations plus completion events from the scoreboard.
  always @(negedge clk) begin
    cyc_t e;
    ev_t  x;
    int   kind;
    if (rst_n && cycQ.size() > 0) begin
      e = cycQ.pop_front();
      checkOutput("stage_start", stage_start, (e.stg >= 0) ? 64'(1 << e.stg) : 64'd0);
      checkOutput("busy", busy, e.busy);
      checkOutput("done", done, e.dn);
      checkOutput("aborted", aborted, e.ab);
      checkOutput("error", error, e.er);
      checkOutput("err_stage", err_stage, e.erStg);
      if (e.stg >= 0) begin
        checkOutput("cur_stage", cur_stage, e.stg);
        checkOutput("mem_we", mem_we, stage_we[e.stg*NM +: NM]);
        checkOutput("mem_addr", mem_addr, stage_addr[e.stg*NM*AW +: NM*AW]);
      end else begin
        checkOutput("mem_we_idle", mem_we, 0);
        checkOutput("mem_addr_idle", mem_addr, 0);
      end
    end
    if (rst_n && (done || aborted || (error && !errPrev))) begin
      kind = done ? 0 : (aborted ? 1 : 2);
      if (evQ.size() == 0) begin
        checkOutput("unexpected_event", kind + 1, 0);
      end else begin
        x = evQ.pop_front();
        checkOutput("event_kind", kind, x.kind);
        checkOutput("event_latency", cycNum - x.startCyc, x.lat);
        for (int k = 0; k < NS; k++)
          checkOutput($sformatf("stage_cycles[%0d]", k), stage_cycles[k*CW +: CW], x.cyc[k]);
        if (kind == 2) checkOutput("event_err_stage", err_stage, x.erStg);
      end
    end
    errPrev = error;
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    stage_enable = '0; timeout_limit = '0; stage_done = '0;
    stage_addr = '0; stage_we = '0;
    #2;
    checkOutput("reset_stage_start", stage_start, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_error", error, 0);
    checkOutput("reset_cycles", stage_cycles, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] three stages, done after 5/10/3 cycles, directed mux on stage 2");
    applyStimulus(3'b111, 5, 10, 3, 0, -1, 0, 1'b1, -1);
    $display("[TB] stage 1 skipped");
    applyStimulus(3'b101, 4, 7, 6, 0, -1, 0, 1'b0, -1);
    $display("[TB] watchdog on stage 1, then restart from error");
    applyStimulus(3'b111, 3, 0, 2, 8, -1, 0, 1'b0, -1);
    applyStimulus(3'b111, 2, 3, 4, 0, -1, 0, 1'b0, -1);
    $display("[TB] abort together with stage 0 done");
    applyStimulus(3'b111, 6, 2, 2, 0, 0, 6, 1'b0, -1);
    $display("[TB] nothing enabled");
    applyStimulus(3'b000, 1, 1, 1, 0, -1, 0, 1'b0, -1);
    $display("[TB] abort during gap");
    applyStimulus(3'b011, 2, 3, 1, 0, 0, 0, 1'b0, -1);
    $display("[TB] asynchronous reset mid-run");
    applyStimulus(3'b111, 4, 4, 4, 0, -1, 0, 1'b0, 6);
    applyStimulus(3'b110, 1, 2, 1, 0, -1, 0, 1'b0, -1);
    $display("[TB] randomized runs");
    for (int n = 0; n < 16; n++) begin
      logic [2:0] en;
      int d[3];
      int lim, abS, abC;
      en  = 3'($urandom_range(0, 7));
      lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 14));
      for (int k = 0; k < NS; k++) begin
        d[k] = $urandom_range(1, 12);
        if (lim > 0 && $urandom_range(0, 3) == 0) d[k] = 0;
      end
      abS = -1;
      abC = 0;
      if ($urandom_range(0, 4) == 0) begin
        abS = $urandom_range(0, 2);
        abC = $urandom_range(0, 6);
      end
      applyStimulus(en, d[0], d[1], d[2], lim, abS, abC, 1'b0, -1);
    end
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("pending_events", evQ.size(), 0);
    checkOutput("pending_cycles", cycQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sift_stage_sequencer.md
Name: sift_stage_sequencer

Overview:
Parametrised top-level pipeline sequencer for the SIFT core. It runs up to NUM_STAGES processing blocks (Gaussian, detect/filter, compute/match, and future stages) in order, using per-stage start/done handshakes. It multiplexes each stage's address and write-enable buses onto NUM_MEM shared SRAM ports. Compared with the fixed 5-state top-level FSM, it adds:
- per-stage skip enables
- a one-cycle inter-stage gap so every stage sees start fall
- abort
- per-stage watchdog timeout with error reporting
- per-stage cycle counters
- return to idle on completion, so it is re-runnable

Parameters:
- NUM_STAGES, 3, number of sequenced stages; stage 0 runs first.
- NUM_MEM, 4, number of shared SRAM ports muxed.
- ADDR_W, 9, SRAM address width per port.
- TIMEOUT_W, 24, width of the watchdog limit and counter.
- CNT_W, 32, width of each per-stage cycle counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low.
- start  in  1  begin a run; sampled in IDLE or ERR.
- abort  in  1  cancel the current run.
- stage_enable  in  NUM_STAGES  bit i=0 skips stage i; sampled only at start.
- timeout_limit  in  TIMEOUT_W  max RUN cycles per stage; 0 disables the watchdog.
- stage_done  in  NUM_STAGES  level/pulse done from each stage.
- stage_addr  in  NUM_STAGES*NUM_MEM*ADDR_W  flattened; stage i, port m at [(i*NUM_MEM+m)*ADDR_W +: ADDR_W].
- stage_we  in  NUM_STAGES*NUM_MEM  stage i, port m at bit i*NUM_MEM+m.
- stage_start  out  NUM_STAGES  one-hot level start to the active stage.
- mem_addr  out  NUM_MEM*ADDR_W  muxed SRAM addresses.
- mem_we  out  NUM_MEM  muxed SRAM write enables.
- cur_stage  out  $clog2(NUM_STAGES)  index of the active or last-active stage.
- busy  out  1  high in RUN and GAP.
- done  out  1  one-cycle pulse on run completion.
- aborted  out  1  one-cycle pulse when an abort is accepted.
- error  out  1  sticky timeout flag.
- err_stage  out  $clog2(NUM_STAGES)  stage that timed out.
- stage_cycles  out  NUM_STAGES*CNT_W  latched RUN-cycle count per stage.

Behaviour:
- Reset: one clock; asynchronous active-low reset rst_n. All outputs and registers are 0, and the state is IDLE.
- States: IDLE, RUN, GAP, FIN, ERR.
- Enable sampling: at accepted start, stage_enable is captured into en_q. Later changes are ignored.
- IDLE/ERR with start=1:
  - clear error, err_stage and all stage_cycles;
  - if en_q has any bit set, go to RUN with cur_stage = lowest set bit and the watchdog counter at 0;
  - otherwise go to FIN.
- ERR without start: hold, with error=1.
- RUN:
  - stage_start[cur_stage]=1; all other bits 0.
  - The counter increments each cycle, saturating at all-ones.
  - Priority per cycle: abort > stage_done[cur_stage] > timeout.
    - abort: go to IDLE and pulse aborted next cycle.
    - done: stage_cycles[cur_stage] = counter+1 (saturated to CNT_W), then go to GAP.
    - timeout (timeout_limit!=0 and counter+1==timeout_limit): error=1, err_stage=cur_stage, go to ERR.
  - stage_done bits of non-current stages are ignored in every state.
- GAP: exactly one cycle with stage_start all 0.
  - Next enabled index above cur_stage: go to RUN with counter cleared.
  - None: go to FIN.
  - abort in GAP: go to IDLE with aborted pulse.
- FIN: done=1 for one cycle, then IDLE. cur_stage holds its value.
- Mux:
  - mem_addr/mem_we are combinational from the cur_stage slice when state==RUN.
  - Otherwise mem_addr=0 and mem_we=0; no writes leak in GAP, IDLE or ERR.
- Latency: start to first stage_start is 1 cycle. done to next stage_start is 2 cycles (done cycle plus GAP).
- Reset mid-run: immediate return to IDLE with all outputs 0. No done or aborted pulse.
- start while busy: ignored.

Decomposition:
- Package sift_pkg holds:
  - the state encoding localparams (ST_IDLE, ST_RUN, ST_GAP, ST_FIN, ST_ERR);
  - a function for next-enabled-stage search (lowest set bit above a given index).
- One natural sub-module: sift_mem_port_mux, the parametrised NUM_STAGES×NUM_MEM address/we selector with gating by a valid input.

Test Plan:
- Three stages all enabled; done asserted after 5, 10 and 3 RUN cycles -> stage_cycles = {3,10,5}.
  - done pulses 1 + 5+1 + 10+1 + 3 + 1 cycles after start.
  - Each stage_start bit drops for exactly one cycle between stages.
- stage_enable=3'b101 -> stage 1 never sees stage_start and stage_cycles[1]=0.
  - Stage-1 stage_done pulsed during stage 0 is ignored.
- timeout_limit=8; stage 1 never done -> error=1 and err_stage=1 after 8 RUN cycles.
  - Then start -> error clears and the run restarts at stage 0.
- abort and stage_done[0] asserted in the same RUN cycle -> aborted pulse, back to IDLE, stage_cycles[0] unchanged, no done.
- During stage 2, stage_addr slice = 9'h1A5 with we=1 on port 3 -> mem_addr port 3 = 9'h1A5 and mem_we=4'b1000.
  - During GAP -> mem_we=0.
- rst_n low asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately.
- stage_enable=0 with start -> done pulse after 1 cycle, busy never high.
